vga_fb_arbiter: RTL and testbench

Owns the single-port frame-buffer RAM behind the 50 MHz VGA timing block. The VGA pixel fetch always has priority inside the display zone. One drawing client writes through a one-entry buffered valid/ready port, and its writes are committed only on blanking cycles. A clear sequencer sweeps the whole buffer with a fixed colour, also only on blanking cycles.

---
 rtl/vga_fb_arbiter.sv | 159 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA fetch owns the RAM in the display zone, while
// a one-entry buffered client write and a full-buffer clear sweep share blanking slots.
module vga_fb_arbiter #(
    parameter int X_BITS = 9,
    parameter int Y_BITS = 9,
    parameter int AW = X_BITS + Y_BITS,
    parameter int DW = 8,
    parameter logic [DW-1:0] CLEAR_COLOR = '0
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic [9:0]    x_pos,
    input  logic [9:0]    y_pos,
    input  logic          display_zone,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb_out,
    output logic          rgb_valid
);

    typedef enum logic [1:0] {EMPTY, FULL, CLEAR} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] buf_addr_reg, buf_addr_next;
    logic [DW-1:0] buf_data_reg, buf_data_next;
    logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
    logic [AW-1:0] addr_next;
    logic [DW-1:0] wdata_next;
    logic          we_next, busy_next, done_next, ready_next;
    logic          wr_hs, clr_start;
    logic          fetch_d1_reg, fetch_d2_reg;
    logic [AW-1:0] fetch_addr;

    // Only the low X_BITS/Y_BITS of the timing counters form the address.
    assign fetch_addr = {y_pos[Y_BITS-1:0], x_pos[X_BITS-1:0]};

    logic unused_pos_bits;
    assign unused_pos_bits = &{1'b0, x_pos, y_pos};

    assign wr_hs     = wr_valid && wr_ready;
    assign clr_start = clear_req && !clear_busy;

    always_comb begin
        state_next    = state_reg;
        buf_addr_next = buf_addr_reg;
        buf_data_next = buf_data_reg;
        clr_cnt_next  = clr_cnt_reg;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        we_next       = 1'b0;
        busy_next     = clear_busy;
        done_next     = 1'b0;

        // RAM slot for this cycle
        if (!display_zone) begin
            addr_next = fetch_addr;
        end else if (state_reg == CLEAR) begin
            addr_next    = clr_cnt_reg;
            we_next      = 1'b1;
            wdata_next   = CLEAR_COLOR;
            clr_cnt_next = clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == {AW{1'b1}}) begin
                state_next = EMPTY;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end
        end else if (state_reg == FULL) begin
            addr_next  = buf_addr_reg;
            we_next    = 1'b1;
            wdata_next = buf_data_reg;
            // a clear flagged while full starts right behind the buffered write
            if (clear_busy) begin
                state_next   = CLEAR;
                clr_cnt_next = '0;
            end else begin
                state_next = EMPTY;
            end
        end

        // Request acceptance
        case (state_reg)
            EMPTY: begin
                if (wr_hs) begin
                    state_next    = FULL;
                    buf_addr_next = wr_addr;
                    buf_data_next = wr_data;
                    if (clr_start) busy_next = 1'b1;
                end else if (clr_start) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                    busy_next    = 1'b1;
                end
            end
            FULL: begin
                if (clr_start) begin
                    busy_next = 1'b1;
                    if (state_next == EMPTY) begin
                        state_next   = CLEAR;
                        clr_cnt_next = '0;
                    end
                end
            end
            default: ;
        endcase

        ready_next = (state_next == EMPTY) && !busy_next;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            buf_addr_reg <= '0;
            buf_data_reg <= '0;
            clr_cnt_reg  <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            wr_ready     <= 1'b1;
            clear_busy   <= 1'b0;
            clear_done   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            buf_addr_reg <= buf_addr_next;
            buf_data_reg <= buf_data_next;
            clr_cnt_reg  <= clr_cnt_next;
            mem_addr     <= addr_next;
            mem_we       <= we_next;
            mem_wdata    <= wdata_next;
            wr_ready     <= ready_next;
            clear_busy   <= busy_next;
            clear_done   <= done_next;
        end
    end

    // Zone flag follows the fetch through address and RAM read stages.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_d1_reg <= 1'b0;
            fetch_d2_reg <= 1'b0;
            rgb_valid    <= 1'b0;
            rgb_out      <= '0;
        end else begin
            fetch_d1_reg <= !display_zone;
            fetch_d2_reg <= fetch_d1_reg;
            rgb_valid    <= fetch_d2_reg;
            rgb_out      <= fetch_d2_reg ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: expected RAM writes and pixels are queued
// at stimulus time and checked by a negedge monitor against a shadow frame buffer.
module tb_vga_fb_arbiter;

    localparam int XB = 3;
    localparam int YB = 3;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = 64;
    localparam logic [7:0] CC = 8'hC3;

    logic          clk_50, rst_n;
    logic [9:0]    x_pos, y_pos;
    logic          display_zone, wr_valid, wr_ready, clear_req, clear_busy, clear_done;
    logic [AW-1:0] wr_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, rgb_out;
    logic          mem_we, rgb_valid;

    vga_fb_arbiter #(.X_BITS(XB), .Y_BITS(YB), .AW(AW), .DW(DW), .CLEAR_COLOR(CC)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .x_pos(x_pos), .y_pos(y_pos),
        .display_zone(display_zone), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
        .clear_busy(clear_busy), .clear_done(clear_done), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rgb_out(rgb_out), .rgb_valid(rgb_valid)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    // Frame-buffer RAM with registered read (old data on a same-cycle write)
    logic [7:0] ram [N];
    always @(posedge clk_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { int addr; int data; bit clr; } wr_t;
    typedef struct { bit v; int d; } px_t;

    wr_t exp_wq[$];
    px_t px_q[$];
    int  shadow [N];
    int  clr_left, clr_pops, last_addr;
    int  s_zone, s_x, s_y;
    bit  s_live;
    int  n_tests, n_fail;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus sampler: decides acceptance from the model and queues expected writes
    always @(posedge clk_50) begin
        if (!rst_n) begin
            s_live = 1'b0;
        end else begin
            bit ready_m, busy_m;
            ready_m = (exp_wq.size() == 0);
            busy_m  = (clr_left > 0);
            s_live  = 1'b1;
            s_zone  = int'(display_zone);
            s_x     = int'(x_pos);
            s_y     = int'(y_pos);
            if (wr_valid && ready_m) begin
                exp_wq.push_back('{int'(wr_addr), int'(wr_data), 1'b0});
                $display("[TB] write accepted addr=%0d data=%02h", wr_addr, wr_data);
            end
            if (clear_req && !busy_m) begin
                for (int i = 0; i < N; i++) exp_wq.push_back('{i, int'(CC), 1'b1});
                clr_left = N;
                clr_pops = 0;
                $display("[TB] clear accepted");
            end
        end
    end

    // Monitor: checks the slot chosen at the last edge, status flags and the pixel stream
    always @(negedge clk_50) begin
        if (rst_n && s_live) begin
            bit done_exp;
            done_exp = 1'b0;
            if (s_zone == 0) begin
                int fa;
                fa = (s_y % 8) * 8 + (s_x % 8);
                chk("fetch_we", int'(mem_we), 0);
                chk("fetch_addr", int'(mem_addr), fa);
                last_addr = fa;
                px_q.push_back('{1'b1, shadow[fa]});
            end else begin
                px_q.push_back('{1'b0, 0});
                if (mem_we) begin
                    if (exp_wq.size() == 0) begin
                        chk("spurious_we", int'(mem_we), 0);
                    end else begin
                        wr_t e;
                        e = exp_wq.pop_front();
                        chk("we_addr", int'(mem_addr), e.addr);
                        chk("we_data", int'(mem_wdata), e.data);
                        shadow[e.addr] = e.data;
                        last_addr = e.addr;
                        if (e.clr) begin
                            clr_left--;
                            clr_pops++;
                            if (clr_left == 0) begin
                                done_exp = 1'b1;
                                $display("[TB] clear sweep complete");
                            end
                        end else begin
                            $display("[TB] write committed addr=%0d data=%02h", e.addr, e.data);
                        end
                    end
                end else begin
                    chk("idle_addr_hold", int'(mem_addr), last_addr);
                end
            end
            chk("wr_ready", int'(wr_ready), int'(exp_wq.size() == 0));
            chk("clear_busy", int'(clear_busy), int'(clr_left > 0));
            chk("clear_done", int'(clear_done), int'(done_exp));
            if (px_q.size() == 3) begin
                px_t p;
                p = px_q.pop_front();
                chk("rgb_valid", int'(rgb_valid), int'(p.v));
                chk("rgb_out", int'(rgb_out), p.d);
            end
        end
    end

    task automatic drv(input bit z, input int x, input int y, input bit wv,
                       input int wa, input int wd, input bit cr);
        display_zone = z;
        x_pos        = 10'(x);
        y_pos        = 10'(y);
        wr_valid     = wv;
        wr_addr      = AW'(wa);
        wr_data      = DW'(wd);
        clear_req    = cr;
        @(posedge clk_50);
        #1;
    endtask

    task automatic rnd_cycle(input int blank_pct, input int wv_pct, input int cr_div);
        drv($urandom_range(0, 99) < blank_pct, $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 99) < wv_pct, $urandom_range(0, N - 1), $urandom_range(0, 255),
            cr_div > 0 && $urandom_range(0, cr_div - 1) == 0);
    endtask

    // Run until the expected write queue empties; client writes only offered during a clear.
    task automatic drain(input int bound, input int blank_pct);
        int k;
        k = 0;
        while (exp_wq.size() > 0 && k < bound) begin
            rnd_cycle(blank_pct, (clr_left > 1) ? 50 : 0, 0);
            k++;
        end
        chk("drain_done", exp_wq.size(), 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_wr_ready"}, int'(wr_ready), 1);
        chk({tag, "_clear_busy"}, int'(clear_busy), 0);
        chk({tag, "_clear_done"}, int'(clear_done), 0);
        chk({tag, "_rgb_out"}, int'(rgb_out), 0);
        chk({tag, "_rgb_valid"}, int'(rgb_valid), 0);
    endtask

    task automatic apply_reset(input string tag);
        display_zone = 1'b1;
        wr_valid     = 1'b0;
        clear_req    = 1'b0;
        #4 rst_n = 1'b0;
        #1;
        reset_check(tag);
        exp_wq.delete();
        px_q.delete();
        clr_left  = 0;
        last_addr = 0;
        s_live    = 1'b0;
        @(posedge clk_50);
        @(posedge clk_50);
        #1 rst_n = 1'b1;
        chk({tag, "_release_ready"}, int'(wr_ready), 1);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; clr_left = 0; clr_pops = 0; last_addr = 0; s_live = 1'b0;
        for (int i = 0; i < N; i++) begin
            ram[i]    = 8'(i);
            shadow[i] = i;
        end
        display_zone = 1'b1; x_pos = '0; y_pos = '0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; clear_req = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 reset_check("rst_init");
        @(posedge clk_50);
        @(posedge clk_50);
        #1 rst_n = 1'b1;
        chk("rst_release_ready", int'(wr_ready), 1);

        // Fetch latency at x=5,y=2, then a sweep of every address with junk upper bits
        drv(1'b0, 5, 2, 1'b0, 0, 0, 1'b0);
        chk("fetch_21_addr", int'(mem_addr), 21);
        for (int i = 0; i < N; i++)
            drv(1'b0, (i % 8) + 8 * $urandom_range(0, 127), (i / 8) + 8 * $urandom_range(0, 127),
                1'b0, 0, 0, 1'b0);
        repeat (3) drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);

        // Write deferred through ten display cycles
        drv(1'b0, 1, 1, 1'b1, 7, 8'hAA, 1'b0);
        repeat (10) drv(1'b0, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, 0, 0, 1'b0);
        drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("defer_we", int'(mem_we), 1);
        drv(1'b0, 7, 0, 1'b0, 0, 0, 1'b0);
        repeat (3) drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);

        // Clear sweep with display cycles interleaved
        drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b1);
        drain(600, 70);
        for (int i = 0; i < 8; i++) drv(1'b0, i, i, 1'b0, 0, 0, 1'b0);

        // Buffered write and clear request on the same edge
        drv(1'b1, 0, 0, 1'b1, 3, 8'h3C, 1'b1);
        drain(600, 70);
        // Clear requested while a deferred write sits in the buffer
        drv(1'b0, 0, 0, 1'b1, 3, 8'h5A, 1'b0);
        drv(1'b0, 3, 0, 1'b0, 0, 0, 1'b1);
        drain(600, 70);
        drv(1'b0, 3, 0, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of a clear, then a fresh clear restarts at address 0
        drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 200 && clr_pops < 20; k++) drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        chk("midclear_progress", clr_pops, 20);
        apply_reset("rst_midclear");
        repeat (8) drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) drv(1'b0, i % 8, i / 8 + 2, 1'b0, 0, 0, 1'b0);
        drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b1);
        drain(600, 80);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) rnd_cycle(60, 30, 250);
        drain(600, 90);
        repeat (4) drv(1'b1, 0, 0, 1'b0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
